// File: rtl/dlfloat_operand_loader.sv
// ---------------------------------------------------------------------------
// dlfloat_operand_loader
//
// Front end for the DLFloat16 MAC. Each DLFloat16 word is sign[15],
// exp[14:9] with bias 31, and mant[8:0]. 0x0000 is zero and 0xFFFF is the
// special/NaN code.
//
// The block collects a byte-serial stream into operand pairs. Bytes arrive
// in the order A lo, A hi, B lo, B hi. Each completed pair is pushed into a
// small FIFO, and the FIFO head is offered to the MAC over a valid/ready
// handshake. The special-value flags for the head pair are computed here,
// so the MAC does not have to compute them.
//
// Ports
//   clk, rst_n     clock; asynchronous active-low reset
//   byte_in        serial operand byte
//   byte_valid     byte_in is valid this cycle
//   byte_ready     loader accepts byte_in this cycle
//   sync_clr       synchronous frame resync; drops any partial pair
//   op_a, op_b     operand pair at the FIFO head (0 when FIFO is empty)
//   op_valid       FIFO non-empty
//   op_ready       MAC consumes the head pair
//   op_special     bit0: A or B is 0x0000; bit1: A or B is 0xFFFF
//   pair_count     pairs pushed since reset, wrapping
//   fifo_level     FIFO occupancy
// ---------------------------------------------------------------------------
module dlfloat_operand_loader #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [7:0]                 byte_in,
  input  logic                       byte_valid,
  output logic                       byte_ready,
  input  logic                       sync_clr,
  output logic [15:0]                op_a,
  output logic [15:0]                op_b,
  output logic                       op_valid,
  input  logic                       op_ready,
  output logic [1:0]                 op_special,
  output logic [CNT_W-1:0]           pair_count,
  output logic [$clog2(DEPTH):0]     fifo_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_ALO = 2'd0,
    S_AHI = 2'd1,
    S_BLO = 2'd2,
    S_BHI = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       a_hold_q, a_hold_d;
  logic [7:0]        b_lo_q, b_lo_d;

  logic [31:0]       mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [CNT_W-1:0]  count_q;

  logic              full, pop, push, byte_acc;
  logic [31:0]       head;

  // Handshake decode
  assign op_valid = (level_q != '0);
  assign full     = (level_q == LVL_W'(DEPTH));
  assign pop      = op_valid && op_ready;

  // The holding registers are separate from the FIFO, so only the final
  // byte of a pair has to wait for FIFO space. A pop in the same cycle
  // frees one slot, which is why op_ready has a combinational path to
  // byte_ready.
  assign byte_ready = !sync_clr && !((state_q == S_BHI) && full && !pop);
  assign byte_acc   = byte_valid && byte_ready;
  assign push       = byte_acc && (state_q == S_BHI);

  // Assembler FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_ALO;
      a_hold_q <= '0;
      b_lo_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments in clocked blocks. Every register
      // then samples values from before the edge, regardless of the
      // order in which the statements are written.
      state_q  <= state_d;
      a_hold_q <= a_hold_d;
      b_lo_q   <= b_lo_d;
    end
  end

  // Assembler FSM: next state and holding-register updates
  always_comb begin
    // NOTE: every signal gets a default before any branch. A path that
    // left one of them unassigned would infer a latch.
    state_d  = state_q;
    a_hold_d = a_hold_q;
    b_lo_d   = b_lo_q;
    if (sync_clr) begin
      state_d  = S_ALO;
      a_hold_d = '0;
      b_lo_d   = '0;
    end else if (byte_acc) begin
      case (state_q)
        S_ALO: begin
          a_hold_d[7:0] = byte_in;
          state_d       = S_AHI;
        end
        S_AHI: begin
          a_hold_d[15:8] = byte_in;
          state_d        = S_BLO;
        end
        S_BLO: begin
          b_lo_d  = byte_in;
          state_d = S_BHI;
        end
        default: state_d = S_ALO;  // S_BHI: the pair is pushed this cycle
      endcase
    end
  end

  // FIFO storage, entry = {A, B}
  // NOTE: the storage array has no reset. An entry is read only after it
  // has been written, and the outputs are forced to zero while the FIFO is
  // empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {a_hold_q, byte_in, b_lo_q};
  end

  assign level_d = level_q + LVL_W'(push) - LVL_W'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      count_q  <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap on natural overflow.
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        count_q  <= count_q + CNT_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_d;
    end
  end

  // Head presentation and special-value flags
  assign head          = mem_q[rd_ptr_q];
  assign op_a          = op_valid ? head[31:16] : 16'h0000;
  assign op_b          = op_valid ? head[15:0]  : 16'h0000;
  assign op_special[0] = op_valid && ((op_a == 16'h0000) || (op_b == 16'h0000));
  assign op_special[1] = op_valid && ((op_a == 16'hFFFF) || (op_b == 16'hFFFF));

  assign pair_count = count_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_dlfloat_operand_loader.sv
// ---------------------------------------------------------------------------
// Testbench for dlfloat_operand_loader (DEPTH = 2, CNT_W = 8).
// The bench applies a fixed vector table and several hand-written corner
// sequences, then a randomized phase. Every cycle is compared against a
// queue-based reference model.
// ---------------------------------------------------------------------------
module tb_dlfloat_operand_loader;

  localparam int DEPTH = 2;
  localparam int CNT_W = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        sync_clr;
  logic [15:0] op_a, op_b;
  logic        op_valid;
  logic        op_ready;
  logic [1:0]  op_special;
  logic [7:0]  pair_count;
  logic [1:0]  fifo_level;

  dlfloat_operand_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .sync_clr   (sync_clr),
    .op_a       (op_a),
    .op_b       (op_b),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_special (op_special),
    .pair_count (pair_count),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of pairs plus the bytes of the pair that is
  // still being assembled.
  logic [15:0] mq_a[$];
  logic [15:0] mq_b[$];
  logic [7:0]  m_bytes[4];
  int          m_idx = 0;
  int          m_cnt = 0;
  int          dut_pops = 0;

  bit          cur_bv, cur_ordy, cur_sc;
  logic [7:0]  cur_b;

  typedef struct {
    bit          bv;
    logic [7:0]  b;
    bit          ordy;
    bit          sc;
    bit          br;
    bit          ov;
    logic [15:0] a;
    logic [15:0] bb;
    logic [1:0]  sp;
    logic [1:0]  lvl;
    logic [7:0]  cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add_vec(input bit bv, input logic [7:0] b, input bit ordy, input bit sc,
                         input bit br, input bit ov, input logic [15:0] a, input logic [15:0] bb,
                         input logic [1:0] sp, input logic [1:0] lvl, input logic [7:0] cnt);
    vec_t v;
    v.bv = bv; v.b = b; v.ordy = ordy; v.sc = sc; v.br = br; v.ov = ov;
    v.a = a; v.bb = bb; v.sp = sp; v.lvl = lvl; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  // Drive one cycle's inputs on the falling edge. Outputs are then sampled
  // 1 ns later, well away from the rising edge.
  task automatic apply(input bit bv, input logic [7:0] b, input bit ordy, input bit sc);
    @(negedge clk);
    cur_bv = bv; cur_b = b; cur_ordy = ordy; cur_sc = sc;
    byte_valid = bv; byte_in = b; op_ready = ordy; sync_clr = sc;
    #1;
  endtask

  task automatic model_reset();
    mq_a.delete();
    mq_b.delete();
    m_idx = 0;
    m_cnt = 0;
  endtask

  // Compare the DUT outputs against the model, then advance the model
  // across the coming rising edge.
  task automatic check_model();
    bit          ev, full, pop, ebr;
    logic [15:0] ea, eb;
    logic [1:0]  esp;
    ev   = (mq_a.size() != 0);
    ea   = ev ? mq_a[0] : 16'h0;
    eb   = ev ? mq_b[0] : 16'h0;
    esp  = {ev && (ea == 16'hFFFF || eb == 16'hFFFF), ev && (ea == 16'h0 || eb == 16'h0)};
    full = (mq_a.size() == DEPTH);
    pop  = ev && cur_ordy;
    ebr  = !cur_sc && !(m_idx == 3 && full && !pop);
    check("model byte_ready", 32'(byte_ready), 32'(ebr));
    check("model op_valid",   32'(op_valid),   32'(ev));
    check("model op_a",       32'(op_a),       32'(ea));
    check("model op_b",       32'(op_b),       32'(eb));
    check("model op_special", 32'(op_special), 32'(esp));
    check("model fifo_level", 32'(fifo_level), mq_a.size());
    check("model pair_count", 32'(pair_count), m_cnt & 255);
    if (op_valid && cur_ordy) dut_pops++;
    if (pop) begin
      void'(mq_a.pop_front());
      void'(mq_b.pop_front());
    end
    if (cur_sc) begin
      m_idx = 0;
    end else if (cur_bv && ebr) begin
      m_bytes[m_idx] = cur_b;
      if (m_idx == 3) begin
        mq_a.push_back({m_bytes[1], m_bytes[0]});
        mq_b.push_back({m_bytes[3], m_bytes[2]});
        m_cnt++;
        m_idx = 0;
      end else begin
        m_idx++;
      end
    end
  endtask

  task automatic step(input bit bv, input logic [7:0] b, input bit ordy, input bit sc);
    apply(bv, b, ordy, sc);
    check_model();
  endtask

  function automatic logic [7:0] rand_byte();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 8'h00;
    if (r == 1) return 8'hFF;
    return 8'($urandom);
  endfunction

  initial begin
    int base_cnt;

    // Vector table.
    // Fields: bv b ordy sc | br ov a b sp lvl cnt.
    // Test 1: one pair with op_ready high.
    add_vec(1, 8'h00, 1, 0, 1, 0, 16'h0000, 16'h0000, 2'b00, 2'd0, 8'd0);
    add_vec(1, 8'h3E, 1, 0, 1, 0, 16'h0000, 16'h0000, 2'b00, 2'd0, 8'd0);
    add_vec(1, 8'h00, 1, 0, 1, 0, 16'h0000, 16'h0000, 2'b00, 2'd0, 8'd0);
    add_vec(1, 8'h40, 1, 0, 1, 0, 16'h0000, 16'h0000, 2'b00, 2'd0, 8'd0);
    add_vec(0, 8'h00, 1, 0, 1, 1, 16'h3E00, 16'h4000, 2'b00, 2'd1, 8'd1);
    add_vec(0, 8'h00, 1, 0, 1, 0, 16'h0000, 16'h0000, 2'b00, 2'd0, 8'd1);
    // Test 2: three pairs into a two-entry FIFO.
    // The last byte is held, then accepted in the same cycle as a pop.
    add_vec(1, 8'h02, 0, 0, 1, 0, 16'h0000, 16'h0000, 2'b00, 2'd0, 8'd1);
    add_vec(1, 8'h01, 0, 0, 1, 0, 16'h0000, 16'h0000, 2'b00, 2'd0, 8'd1);
    add_vec(1, 8'h04, 0, 0, 1, 0, 16'h0000, 16'h0000, 2'b00, 2'd0, 8'd1);
    add_vec(1, 8'h03, 0, 0, 1, 0, 16'h0000, 16'h0000, 2'b00, 2'd0, 8'd1);
    add_vec(1, 8'h06, 0, 0, 1, 1, 16'h0102, 16'h0304, 2'b00, 2'd1, 8'd2);
    add_vec(1, 8'h05, 0, 0, 1, 1, 16'h0102, 16'h0304, 2'b00, 2'd1, 8'd2);
    add_vec(1, 8'h08, 0, 0, 1, 1, 16'h0102, 16'h0304, 2'b00, 2'd1, 8'd2);
    add_vec(1, 8'h07, 0, 0, 1, 1, 16'h0102, 16'h0304, 2'b00, 2'd1, 8'd2);
    add_vec(1, 8'h0A, 0, 0, 1, 1, 16'h0102, 16'h0304, 2'b00, 2'd2, 8'd3);
    add_vec(1, 8'h09, 0, 0, 1, 1, 16'h0102, 16'h0304, 2'b00, 2'd2, 8'd3);
    add_vec(1, 8'h0C, 0, 0, 1, 1, 16'h0102, 16'h0304, 2'b00, 2'd2, 8'd3);
    add_vec(1, 8'h0B, 0, 0, 0, 1, 16'h0102, 16'h0304, 2'b00, 2'd2, 8'd3);
    add_vec(1, 8'h0B, 1, 0, 1, 1, 16'h0102, 16'h0304, 2'b00, 2'd2, 8'd3);
    add_vec(0, 8'h00, 1, 0, 1, 1, 16'h0506, 16'h0708, 2'b00, 2'd2, 8'd4);
    add_vec(0, 8'h00, 1, 0, 1, 1, 16'h090A, 16'h0B0C, 2'b00, 2'd1, 8'd4);
    add_vec(0, 8'h00, 1, 0, 1, 0, 16'h0000, 16'h0000, 2'b00, 2'd0, 8'd4);
    // Test 4: special-value flags.
    add_vec(1, 8'h00, 0, 0, 1, 0, 16'h0000, 16'h0000, 2'b00, 2'd0, 8'd4);
    add_vec(1, 8'h00, 0, 0, 1, 0, 16'h0000, 16'h0000, 2'b00, 2'd0, 8'd4);
    add_vec(1, 8'h00, 0, 0, 1, 0, 16'h0000, 16'h0000, 2'b00, 2'd0, 8'd4);
    add_vec(1, 8'h40, 0, 0, 1, 0, 16'h0000, 16'h0000, 2'b00, 2'd0, 8'd4);
    add_vec(1, 8'hFF, 0, 0, 1, 1, 16'h0000, 16'h4000, 2'b01, 2'd1, 8'd5);
    add_vec(1, 8'hFF, 0, 0, 1, 1, 16'h0000, 16'h4000, 2'b01, 2'd1, 8'd5);
    add_vec(1, 8'h00, 0, 0, 1, 1, 16'h0000, 16'h4000, 2'b01, 2'd1, 8'd5);
    add_vec(1, 8'h3E, 0, 0, 1, 1, 16'h0000, 16'h4000, 2'b01, 2'd1, 8'd5);
    add_vec(0, 8'h00, 1, 0, 1, 1, 16'h0000, 16'h4000, 2'b01, 2'd2, 8'd6);
    add_vec(0, 8'h00, 1, 0, 1, 1, 16'hFFFF, 16'h3E00, 2'b10, 2'd1, 8'd6);
    add_vec(0, 8'h00, 0, 0, 1, 0, 16'h0000, 16'h0000, 2'b00, 2'd0, 8'd6);

    // Reset
    rst_n = 1'b0; byte_valid = 1'b0; byte_in = 8'h00; op_ready = 1'b0; sync_clr = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset op_valid",   32'(op_valid),   32'd0);
    check("reset op_a",       32'(op_a),       32'd0);
    check("reset op_special", 32'(op_special), 32'd0);
    check("reset pair_count", 32'(pair_count), 32'd0);
    check("reset fifo_level", 32'(fifo_level), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset byte_ready", 32'(byte_ready), 32'd1);
    model_reset();

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].bv, vecs[i].b, vecs[i].ordy, vecs[i].sc);
      check($sformatf("vec%0d byte_ready", i), 32'(byte_ready), 32'(vecs[i].br));
      check($sformatf("vec%0d op_valid", i),   32'(op_valid),   32'(vecs[i].ov));
      check($sformatf("vec%0d op_a", i),       32'(op_a),       32'(vecs[i].a));
      check($sformatf("vec%0d op_b", i),       32'(op_b),       32'(vecs[i].bb));
      check($sformatf("vec%0d op_special", i), 32'(op_special), 32'(vecs[i].sp));
      check($sformatf("vec%0d fifo_level", i), 32'(fifo_level), 32'(vecs[i].lvl));
      check($sformatf("vec%0d pair_count", i), 32'(pair_count), 32'(vecs[i].cnt));
      check_model();
    end

    // Test 3: sync_clr drops a partial pair and blocks the byte that is
    // offered in the same cycle.
    base_cnt = 6;
    step(1, 8'hAA, 0, 0);
    step(1, 8'hBB, 0, 0);
    step(1, 8'hCC, 0, 0);
    apply(1, 8'hDD, 0, 1);
    check("sync_clr byte_ready", 32'(byte_ready), 32'd0);
    check_model();
    step(1, 8'h11, 0, 0);
    step(1, 8'h22, 0, 0);
    step(1, 8'h33, 0, 0);
    step(1, 8'h44, 0, 0);
    apply(0, 8'h00, 0, 0);
    check("sync_clr op_a",       32'(op_a),       32'h2211);
    check("sync_clr op_b",       32'(op_b),       32'h4433);
    check("sync_clr pair_count", 32'(pair_count), base_cnt + 1);
    check("sync_clr fifo_level", 32'(fifo_level), 32'd1);
    check_model();
    step(0, 8'h00, 1, 0);

    // Test 5: asynchronous reset in the middle of a frame, with one pair
    // already in the FIFO.
    step(1, 8'h01, 0, 0);
    step(1, 8'h02, 0, 0);
    step(1, 8'h03, 0, 0);
    step(1, 8'h04, 0, 0);
    step(1, 8'h05, 0, 0);
    step(1, 8'h06, 0, 0);
    @(negedge clk);
    byte_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midreset op_valid",   32'(op_valid),   32'd0);
    check("midreset op_a",       32'(op_a),       32'd0);
    check("midreset op_b",       32'(op_b),       32'd0);
    check("midreset pair_count", 32'(pair_count), 32'd0);
    check("midreset fifo_level", 32'(fifo_level), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 8'h10, 0, 0);
    step(1, 8'h20, 0, 0);
    step(1, 8'h30, 0, 0);
    step(1, 8'h40, 0, 0);
    apply(0, 8'h00, 1, 0);
    check("postreset op_a",       32'(op_a),       32'h2010);
    check("postreset op_b",       32'(op_b),       32'h4030);
    check("postreset pair_count", 32'(pair_count), 32'd1);
    check_model();

    // Randomized phase against the model
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 9) < 7, rand_byte(), $urandom_range(0, 1) == 1,
           $urandom_range(0, 19) == 0);
    end

    // Test 6: 256 pairs with op_ready high. The counter wraps to zero,
    // and the scoreboard catches any lost or duplicated pair.
    @(negedge clk);
    rst_n = 1'b0;
    byte_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    dut_pops = 0;
    for (int p = 0; p < 256; p++) begin
      for (int k = 0; k < 4; k++) step(1, rand_byte(), 1, 0);
    end
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 1, 0);
    check("wrap pair_count", 32'(pair_count), 32'd0);
    check("wrap pops",       dut_pops,        32'd256);
    check("wrap fifo_level", 32'(fifo_level), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dlfloat_operand_loader.md
Name: dlfloat_operand_loader

Overview:
- Upstream feeder for the DLFloat16 MAC (format: sign[15], exp[14:9] bias 31, mant[8:0]; 0x0000 = zero, 0xFFFF = special/NaN).
- Takes a byte-serial stream from the 8-bit pad interface and assembles each 4-byte group into an operand pair (A, B).
- Buffers completed pairs in a small FIFO and presents them to the MAC over a valid/ready handshake, with special-value flags precomputed.

Parameters:
- DEPTH, 2, FIFO entries of {A,B}; power of two, >= 2.
- CNT_W, 8, width of the accepted-pair counter.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- byte_in  input  8  serial operand byte.
- byte_valid  input  1  byte_in is valid this cycle.
- byte_ready  output  1  loader accepts byte_in this cycle.
- sync_clr  input  1  synchronous frame resync; discards a partial pair.
- op_a  output  16  operand A at FIFO head.
- op_b  output  16  operand B at FIFO head.
- op_valid  output  1  FIFO non-empty; head pair valid.
- op_ready  input  1  MAC consumes the head pair.
- op_special  output  2  bit0 = A or B == 0x0000; bit1 = A or B == 0xFFFF (head pair).
- pair_count  output  CNT_W  pairs pushed into the FIFO since reset, wrapping.
- fifo_level  output  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Byte accept: a byte is accepted when byte_valid && byte_ready. Byte order per pair is A[7:0], A[15:8], B[7:0], B[15:8].
- Assembler FSM states: S_ALO -> S_AHI -> S_BLO -> S_BHI -> S_ALO. Each state advances only on an accepted byte. S_ALO/S_AHI write the A holding register; S_BLO writes the B low holding byte.
- Push: the byte accepted in S_BHI pushes {A_hold, B_hi:B_lo_hold} into the FIFO in that same cycle, and pair_count increments (wraps at 2^CNT_W).
- byte_ready: 0 only when state == S_BHI and FIFO is full and no pop occurs this cycle (combinational on op_ready). It is 1 in all other states, even when the FIFO is full, because holding registers are independent of the FIFO.
- Pop: op_valid && op_ready pops the head. The new head is visible on op_a/op_b the next cycle.
- Simultaneous push and pop:
  - When full: allowed; level unchanged.
  - When empty: push only takes effect (op_valid is 0, so no pop); op_valid rises the next cycle.
- Latency: last byte accepted at cycle N -> op_valid = 1 at N+1 (FIFO registered, no bypass).
- Empty FIFO outputs: op_a, op_b, op_special are forced to 0 when op_valid = 0.
- op_special is combinational from the head entry.
- sync_clr:
  - FSM returns to S_ALO next cycle and holding registers clear to 0.
  - Any byte presented in the same cycle is not accepted (byte_ready = 0 while sync_clr = 1) and no push occurs.
  - The FIFO, pop side and pair_count are unaffected.
- Reset (async, any time, including mid-frame):
  - FSM = S_ALO; holding registers, FIFO pointers, pair_count and fifo_level = 0.
  - op_valid = 0, op_a = op_b = 0, op_special = 0, byte_ready = 1 after reset is released.
- Pointers: wrap modulo DEPTH. Full/empty are distinguished by fifo_level (or an extra pointer bit).
- Data path: bytes are not modified; no arithmetic on operands apart from the equality compares for op_special.

Test Plan:
- Reset, then bytes 0x00,0x3E,0x00,0x40 (A = 0x3E00, B = 0x4000), op_ready = 1 -> op_valid = 1 one cycle after the 4th byte; op_a = 0x3E00, op_b = 0x4000, op_special = 0; pair_count = 1; popped next edge.
- op_ready = 0; stream 3 pairs with DEPTH = 2 -> fifo_level = 2; byte_ready = 0 while the 4th byte of pair 3 is held (FSM in S_BHI). Raise op_ready -> that byte is accepted the same cycle as the pop; fifo_level stays 2; pairs emerge in order.
- Send A bytes plus B low byte, assert sync_clr with byte_valid = 1 -> byte not accepted; next 4 bytes 0x11,0x22,0x33,0x44 yield op_a = 0x2211, op_b = 0x4433; pair_count increments by 1 only.
- Pairs (0x0000, 0x4000) and (0xFFFF, 0x3E00) -> op_special = 2'b01 then 2'b10.
- Assert rst_n low after 2 bytes of a pair with 1 pair in the FIFO -> op_valid = 0 immediately; op_a = 0, op_b = 0, pair_count = 0; next 4 bytes form a clean pair.
- Push 256 pairs with op_ready = 1 -> pair_count wraps to 0x00; no lost or duplicated pairs (scoreboard).
